// File: rtl/seq_div_8bit.sv
// Multi-cycle restoring divider producing one quotient bit per clock behind a start/done handshake.
// Optional signed (truncating) division when SIGNED_DIV_EN is defined.
module seq_div_8bit #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             start_in,
`ifdef SIGNED_DIV_EN
  input  logic             signed_in,
`endif
  input  logic [WIDTH-1:0] dividend_in,
  input  logic [WIDTH-1:0] divisor_in,
  output logic             busy_out,
  output logic             done_out,
  output logic [WIDTH-1:0] quotient_out,
  output logic [WIDTH-1:0] remainder_out,
  output logic             div_by_zero_out
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   quot_q, quot_d;
  logic [WIDTH-1:0]   dvsr_q, dvsr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               neg_quot_q, neg_quot_d;
  logic               neg_rem_q, neg_rem_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   quot_out_q, quot_out_d;
  logic [WIDTH-1:0]   rem_out_q, rem_out_d;
  logic               dbz_q, dbz_d;

  logic               signed_mode_c;
  logic [WIDTH-1:0]   rem_sh_c;
  logic [WIDTH:0]     trial_c;

`ifdef SIGNED_DIV_EN
  assign signed_mode_c = signed_in;
`else
  assign signed_mode_c = 1'b0;
`endif

  // Magnitude of a two's-complement operand when signed mode is active.
  function automatic logic [WIDTH-1:0] mag_f(input logic [WIDTH-1:0] x, input logic en);
    return (en && x[WIDTH-1]) ? (~x + WIDTH'(1)) : x;
  endfunction

  function automatic logic [WIDTH-1:0] negate_f(input logic [WIDTH-1:0] x, input logic en);
    return en ? (~x + WIDTH'(1)) : x;
  endfunction

  // State register with synchronous active-low reset.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state_q    <= S_IDLE;
      rem_q      <= '0;
      quot_q     <= '0;
      dvsr_q     <= '0;
      cnt_q      <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      quot_out_q <= '0;
      rem_out_q  <= '0;
      dbz_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      quot_q     <= quot_d;
      dvsr_q     <= dvsr_d;
      cnt_q      <= cnt_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      quot_out_q <= quot_out_d;
      rem_out_q  <= rem_out_d;
      dbz_q      <= dbz_d;
    end
  end

  // Next-state, iteration datapath and result capture.
  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    quot_d     = quot_q;
    dvsr_d     = dvsr_q;
    cnt_d      = cnt_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    done_d     = 1'b0;
    quot_out_d = quot_out_q;
    rem_out_d  = rem_out_q;
    dbz_d      = dbz_q;

    // Shift {rem,quot} left by one, then trial-subtract the divisor.
    rem_sh_c = {rem_q[WIDTH-2:0], quot_q[WIDTH-1]};
    trial_c  = {1'b0, rem_sh_c} + {1'b0, ~dvsr_q} + (WIDTH+1)'(1);

    unique case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start_in) begin
          rem_d      = '0;
          quot_d     = mag_f(dividend_in, signed_mode_c);
          dvsr_d     = mag_f(divisor_in, signed_mode_c);
          cnt_d      = '0;
          neg_quot_d = signed_mode_c && (dividend_in[WIDTH-1] ^ divisor_in[WIDTH-1]);
          neg_rem_d  = signed_mode_c && dividend_in[WIDTH-1];
          if (divisor_in == '0) begin
            state_d    = S_DONE;
            done_d     = 1'b1;
            quot_out_d = '1;
            rem_out_d  = dividend_in;
            dbz_d      = 1'b1;
          end else begin
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        rem_d  = trial_c[WIDTH] ? trial_c[WIDTH-1:0] : rem_sh_c;
        quot_d = {quot_q[WIDTH-2:0], trial_c[WIDTH]};
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d    = S_DONE;
          done_d     = 1'b1;
          quot_out_d = negate_f(quot_d, neg_quot_q);
          rem_out_d  = negate_f(rem_d, neg_rem_q);
          dbz_d      = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_RUN);
  end

  assign busy_out        = busy_q;
  assign done_out        = done_q;
  assign quotient_out    = quot_out_q;
  assign remainder_out   = rem_out_q;
  assign div_by_zero_out = dbz_q;

endmodule

// File: tb/tb_seq_div_8bit.sv
// Directed self-checking bench for seq_div_8bit (default unsigned build).
module tb_seq_div_8bit;

  localparam int unsigned WIDTH = 8;

  logic             clk_in;
  logic             rst_n_in;
  logic             start_in;
  logic [WIDTH-1:0] dividend_in;
  logic [WIDTH-1:0] divisor_in;
  logic             busy_out;
  logic             done_out;
  logic [WIDTH-1:0] quotient_out;
  logic [WIDTH-1:0] remainder_out;
  logic             div_by_zero_out;

  int checks;
  int errors;

  seq_div_8bit #(.WIDTH(WIDTH)) dut (
    .clk_in          (clk_in),
    .rst_n_in        (rst_n_in),
    .start_in        (start_in),
    .dividend_in     (dividend_in),
    .divisor_in      (divisor_in),
    .busy_out        (busy_out),
    .done_out        (done_out),
    .quotient_out    (quotient_out),
    .remainder_out   (remainder_out),
    .div_by_zero_out (div_by_zero_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // Advance one rising edge and settle 1 time unit after it.
  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Edges until done_out rises; -1 if the bound expires.
  task automatic wait_done(output int n);
    n = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (done_out) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic start_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    start_in    = 1'b1;
    dividend_in = a;
    divisor_in  = b;
    tick();
    start_in    = 1'b0;
  endtask

  initial begin
    int n;
    bit saw_done;
    checks      = 0;
    errors      = 0;
    rst_n_in    = 1'b0;
    start_in    = 1'b0;
    dividend_in = '0;
    divisor_in  = '0;
    tick();
    tick();
    check("rst_busy", 32'(busy_out), 0);
    check("rst_done", 32'(done_out), 0);
    check("rst_q", 32'(quotient_out), 0);
    check("rst_r", 32'(remainder_out), 0);
    check("rst_dbz", 32'(div_by_zero_out), 0);
    rst_n_in = 1'b1;
    tick();

    // 200/7: busy for 8 cycles, done after 8 edges
    start_op(8'd200, 8'd7);
    check("t1_busy_first", 32'(busy_out), 1);
    dividend_in = 8'd3;
    divisor_in  = 8'd3;
    for (int i = 0; i < 7; i++) tick();
    check("t1_busy_last", 32'(busy_out), 1);
    check("t1_nodone_early", 32'(done_out), 0);
    tick();
    check("t1_done", 32'(done_out), 1);
    check("t1_busy_off", 32'(busy_out), 0);
    check("t1_q", 32'(quotient_out), 28);
    check("t1_r", 32'(remainder_out), 4);
    check("t1_dbz", 32'(div_by_zero_out), 0);
    tick();
    check("t1_done_pulse", 32'(done_out), 0);
    check("t1_q_held", 32'(quotient_out), 28);

    // 255/1 then back-to-back 0/9 from the DONE cycle
    start_op(8'd255, 8'd1);
    wait_done(n);
    check("t2a_latency", 32'(n), 8);
    check("t2a_q", 32'(quotient_out), 255);
    check("t2a_r", 32'(remainder_out), 0);
    start_op(8'd0, 8'd9);
    check("t2b_no_gap_busy", 32'(busy_out), 1);
    wait_done(n);
    check("t2b_latency", 32'(n), 8);
    check("t2b_q", 32'(quotient_out), 0);
    check("t2b_r", 32'(remainder_out), 0);

    // 5/0: done next cycle, then 9/3 clears the flag
    tick();
    start_op(8'd5, 8'd0);
    check("t3_dbz_done", 32'(done_out), 1);
    check("t3_dbz_busy", 32'(busy_out), 0);
    check("t3_dbz_q", 32'(quotient_out), 255);
    check("t3_dbz_r", 32'(remainder_out), 5);
    check("t3_dbz_flag", 32'(div_by_zero_out), 1);
    tick();
    check("t3_dbz_pulse", 32'(done_out), 0);
    check("t3_dbz_held", 32'(div_by_zero_out), 1);
    start_op(8'd9, 8'd3);
    check("t3_flag_held_run", 32'(div_by_zero_out), 1);
    wait_done(n);
    check("t3_latency", 32'(n), 8);
    check("t3_q", 32'(quotient_out), 3);
    check("t3_r", 32'(remainder_out), 0);
    check("t3_flag_clr", 32'(div_by_zero_out), 0);

    // start pulsed with 1/1 during RUN of 100/10 is ignored
    tick();
    start_op(8'd100, 8'd10);
    tick();
    tick();
    start_op(8'd1, 8'd1);
    wait_done(n);
    check("t4_latency", 32'(n), 5);
    check("t4_q", 32'(quotient_out), 10);
    check("t4_r", 32'(remainder_out), 0);
    tick();
    check("t4_idle_after", 32'(busy_out), 0);

    // reset at iteration 4 of 77/5 aborts silently
    start_op(8'd77, 8'd5);
    tick();
    tick();
    tick();
    rst_n_in = 1'b0;
    tick();
    check("t5_busy", 32'(busy_out), 0);
    check("t5_done", 32'(done_out), 0);
    check("t5_q", 32'(quotient_out), 0);
    check("t5_r", 32'(remainder_out), 0);
    check("t5_dbz", 32'(div_by_zero_out), 0);
    rst_n_in = 1'b1;
    saw_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done_out || busy_out) saw_done = 1'b1;
    end
    check("t5_no_done", 32'(saw_done), 0);

    // post-reset sanity: 13/4 and 254/255
    start_op(8'd13, 8'd4);
    wait_done(n);
    check("t6_latency", 32'(n), 8);
    check("t6_q", 32'(quotient_out), 3);
    check("t6_r", 32'(remainder_out), 1);
    start_op(8'd254, 8'd255);
    wait_done(n);
    check("t7_q", 32'(quotient_out), 0);
    check("t7_r", 32'(remainder_out), 254);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
